// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between the core load/store path
//               (master) and the data-memory responder (slave).
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request this cycle
//   req_write  master->slave  1 = store, 0 = load
//   req_addr   master->slave  32-bit byte address
//   req_wdata  master->slave  32-bit store data
//   resp_valid slave->master  one-cycle response pulse
//   resp_rdata slave->master  load data, zero unless resp_valid
//   resp_err   slave->master  access faulted, valid with resp_valid
//   busy       slave->master  request in flight (core stall)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Registered, fixed-latency 32-bit word memory for the core's
//               data port. One request at a time; each is answered by a
//               single-cycle resp_valid pulse LATENCY+1 cycles after accept.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-low reset
//               bus   - dmem_responder_if.slave (request/response/busy)
// Parameters  : DEPTH_WORDS - word count, power of two, >= 4
//               LATENCY     - wait cycles between accept and response, 0..15
// Options     : MISALIGN_CHK_EN - when defined, req_addr[1:0] != 0 faults;
//               otherwise the low address bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus
);

  localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LAT   = 4'(LATENCY);
`ifdef MISALIGN_CHK_EN
  localparam bit         c_MISALIGN_CHK = 1'b1;
`else
  localparam bit         c_MISALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_count;
  logic [3:0]  w_count_next;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  // Operation being executed: taken straight from the bus in IDLE so a
  // zero-latency request can complete on its accepting edge, otherwise from
  // the captured copy.
  logic               w_idle;
  logic               w_op_write;
  logic [31:0]        w_op_addr;
  logic [31:0]        w_op_wdata;
  logic               w_accept;
  logic               w_enter_resp;
  logic               w_range_err;
  logic               w_misalign;
  logic               w_fault;
  logic [c_IDX_W-1:0] w_idx;

  assign w_idle     = (r_state == S_IDLE);
  assign w_op_write = w_idle ? bus.req_write : r_write;
  assign w_op_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_op_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_accept   = w_idle && bus.req_valid;

  // The memory access happens exactly once, on the edge that enters RESP.
  assign w_enter_resp = (w_next == S_RESP);

  assign w_range_err = |w_op_addr[31:c_IDX_W+2];
  assign w_misalign  = |w_op_addr[1:0];
  assign w_fault     = w_range_err | (c_MISALIGN_CHK & w_misalign);
  assign w_idx       = w_op_addr[c_IDX_W+1:2];

  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_count_next = c_LAT;
          w_next       = (c_LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_count_next = r_count - 4'd1;
        if (r_count <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      // Response registers are non-zero only during the RESP cycle.
      if (w_enter_resp) begin
        r_err   <= w_fault;
        r_rdata <= (w_fault || w_op_write) ? 32'd0 : r_mem[w_idx];
      end else begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Storage is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_op_write && !w_fault) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule
`default_nettype wire
